// File: rtl/note_sequencer_if.sv
// note_sequencer_if
//   Groups the step/keyboard/button inputs and the playback/status outputs of
//   the note sequencer into one bundle.
//   master : the controller side (timer tick, keyboard, buttons); observes status.
//   slave  : the sequencer itself.
//   Signals:
//     tick        step pulse, one slot per tick
//     key_code    currently pressed note (0 = rest), sampled on tick
//     record_btn  one-cycle pulse, start/stop recording
//     play_btn    one-cycle pulse, start/abort playback
//     note_out    registered note to the tone generator
//     note_active note_out is non-zero
//     recording   sequencer is recording
//     playing     sequencer is playing
//     length      number of stored slots, 0..DEPTH
//     done        one-cycle pulse at the natural end of playback
interface note_sequencer_if #(
  parameter int DEPTH  = 16,
  parameter int NOTE_W = 4
);
  localparam int LEN_W = $clog2(DEPTH) + 1;

  logic              tick;
  logic [NOTE_W-1:0] key_code;
  logic              record_btn;
  logic              play_btn;
  logic [NOTE_W-1:0] note_out;
  logic              note_active;
  logic              recording;
  logic              playing;
  logic [LEN_W-1:0]  length;
  logic              done;

  modport master (
    output tick, key_code, record_btn, play_btn,
    input  note_out, note_active, recording, playing, length, done
  );

  modport slave (
    input  tick, key_code, record_btn, play_btn,
    output note_out, note_active, recording, playing, length, done
  );
endinterface

// File: rtl/note_sequencer.sv
// note_sequencer
//   Records up to DEPTH notes, one per tick, and plays them back one per tick.
//   Three states: IDLE, RECORD, PLAY. A new recording discards the previous
//   take; recording stops on record_btn or when the store is full. Playback
//   ends naturally one tick after the last note (done pulse) or is aborted by
//   play_btn (no done pulse).
//   Ports:
//     clock  system clock, rising edge
//     clear  synchronous active-low reset
//     bus    note_sequencer_if slave modport (see interface file)
module note_sequencer #(
  parameter int DEPTH  = 16,
  parameter int NOTE_W = 4
) (
  input  logic          clock,
  input  logic          clear,
  note_sequencer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LEN_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECORD = 2'd1,
    S_PLAY   = 2'd2
  } state_t;

  state_t            state_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  // rd_ptr needs one extra bit: it reaches length (up to DEPTH) before the
  // end-of-playback tick. It is only used as an index while rd_ptr < length.
  logic [LEN_W-1:0]  rd_ptr_q;
  logic [LEN_W-1:0]  length_q;
  logic [NOTE_W-1:0] note_out_q;
  logic              done_q;

  logic [NOTE_W-1:0] mem [DEPTH];
  logic              mem_we;

  // A write happens only on a tick in RECORD that is not overridden by
  // record_btn or reset. RECORD always has length < DEPTH, so no overflow.
  assign mem_we = clear && (state_q == S_RECORD) && bus.tick && !bus.record_btn;

  // Note storage: contents are never reset, length makes stale slots unreachable.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= bus.key_code;
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      length_q   <= '0;
      note_out_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          note_out_q <= '0;
          // record_btn has priority over play_btn; ticks are ignored here.
          if (bus.record_btn) begin
            state_q  <= S_RECORD;
            wr_ptr_q <= '0;
            length_q <= '0;
          end else if (bus.play_btn && (length_q != '0)) begin
            state_q  <= S_PLAY;
            rd_ptr_q <= '0;
          end
        end

        S_RECORD: begin
          note_out_q <= '0;
          if (bus.record_btn) begin
            state_q <= S_IDLE;
          end else if (bus.tick) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            length_q <= length_q + LEN_W'(1);
            // This write fills the last slot: stop recording on the same edge.
            if (length_q == LEN_W'(DEPTH - 1)) begin
              state_q <= S_IDLE;
            end
          end
        end

        S_PLAY: begin
          if (bus.play_btn) begin
            state_q    <= S_IDLE;
            note_out_q <= '0;
          end else if (bus.tick) begin
            if (rd_ptr_q < length_q) begin
              note_out_q <= mem[rd_ptr_q[PTR_W-1:0]];
              rd_ptr_q   <= rd_ptr_q + LEN_W'(1);
            end else begin
              // Extra tick after the last note so it sounds a full period.
              note_out_q <= '0;
              done_q     <= 1'b1;
              state_q    <= S_IDLE;
            end
          end
        end

        default: begin
          state_q    <= S_IDLE;
          note_out_q <= '0;
        end
      endcase
    end
  end

  assign bus.note_out    = note_out_q;
  assign bus.note_active = (note_out_q != '0);
  assign bus.recording   = (state_q == S_RECORD);
  assign bus.playing     = (state_q == S_PLAY);
  assign bus.length      = length_q;
  assign bus.done        = done_q;
endmodule
